// File: rtl/sigma_delta_dac.sv
// sigma_delta_dac: first-order accumulator-carry sigma-delta modulator.
// Turns an unsigned CODE_WIDTH-bit code into a 1-bit pulse-density stream
// whose density of ones is code / 2^CODE_WIDTH.
//
// Ports:
//   clk  - system clock, rising-edge active
//   rst  - asynchronous reset, active-low
//   code - unsigned density code, sampled every cycle
//   pwm  - registered pulse-density output
//
// Optional feature macro: SD_DAC_CODE_REG_EN
//   Defined:   code is captured into an input register first (2-edge latency).
//   Undefined: code feeds the adder directly (1-edge latency).
module sigma_delta_dac #(
  parameter int unsigned CODE_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CODE_WIDTH-1:0] code,
  output logic                  pwm
);

  localparam int unsigned SUM_W = CODE_WIDTH + 1;

  logic [CODE_WIDTH-1:0] acc_q;
  logic [CODE_WIDTH-1:0] acc_d;
  logic                  pwm_q;
  logic                  pwm_d;
  logic [CODE_WIDTH-1:0] add_code;
  logic [SUM_W-1:0]      sum;

`ifdef SD_DAC_CODE_REG_EN
  logic [CODE_WIDTH-1:0] code_q;
  logic [CODE_WIDTH-1:0] code_d;

  // Input capture register; the adder sees the previous cycle's code.
  always_comb begin
    code_d = code;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q <= '0;
    end else begin
      code_q <= code_d;
    end
  end

  assign add_code = code_q;
`else
  assign add_code = code;
`endif

  // Full-width add: the low bits wrap into the accumulator, the carry is the pulse.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, add_code};
    acc_d = sum[CODE_WIDTH-1:0];
    pwm_d = sum[CODE_WIDTH];
  end

  // Accumulator and output flop; both cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: tb/tb_sigma_delta_dac.sv
// tb_sigma_delta_dac: directed self-checking bench for sigma_delta_dac
// (CODE_WIDTH = 10). Counts ones over fixed edge windows after reset and
// compares against hand-computed densities, plus boundary and reset cases.
module tb_sigma_delta_dac;

  localparam int unsigned CW = 10;
  localparam int unsigned PERIOD_EDGES = 1 << CW;
`ifdef SD_DAC_CODE_REG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk;
  logic          rst;
  logic [CW-1:0] code;
  logic          pwm;

  int tests;
  int failed;
  int ones;
  int first;
  int seg1;
  int budget;

  sigma_delta_dac #(.CODE_WIDTH(CW)) dut (
    .clk  (clk),
    .rst  (rst),
    .code (code),
    .pwm  (pwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Assert reset with the given code applied, then release on a falling edge.
  task automatic do_reset(input logic [CW-1:0] c);
    @(negedge clk);
    rst  = 1'b0;
    code = c;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Count ones over n edges, sampling 1 time unit after each rising edge;
  // also report the edge index of the first one (0 if none).
  task automatic run_count(input int n, output int cnt, output int first_one);
    cnt       = 0;
    first_one = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (pwm === 1'b1) begin
        cnt++;
        if (first_one == 0) first_one = i;
      end
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    code   = '0;

    // Reset value, observed while rst is held low.
    #2 rst = 1'b0;
    #1 check("reset_pwm", int'(pwm), 0);

    // code = 0: never a pulse.
    do_reset(10'd0);
    run_count(3 * PERIOD_EDGES + EXTRA, ones, first);
    check("code0_count", ones, 0);
    check("code0_first", first, 0);

    // code = 1: three pulses, first on edge 1024.
    do_reset(10'd1);
    run_count(3 * PERIOD_EDGES + EXTRA, ones, first);
    check("code1_count", ones, 3);
    check("code1_first", first, 1024 + EXTRA);

    do_reset(10'd32);
    run_count(3 * PERIOD_EDGES + EXTRA, ones, first);
    check("code32_count", ones, 96);

    do_reset(10'd300);
    run_count(3 * PERIOD_EDGES + EXTRA, ones, first);
    check("code300_count", ones, 900);

    do_reset(10'd774);
    run_count(3 * PERIOD_EDGES + EXTRA, ones, first);
    check("code774_count", ones, 2322);

    do_reset(10'd1000);
    run_count(3 * PERIOD_EDGES + EXTRA, ones, first);
    check("code1000_count", ones, 3000);

    // Near full scale: exactly one zero per 1024 edges.
    do_reset(10'd1023);
    run_count(3 * PERIOD_EDGES + EXTRA, ones, first);
    check("code1023_count", ones, 3069);

    // Half scale: strict 0,1,0,1 alternation.
    do_reset(10'd512);
    if (EXTRA > 0) run_count(EXTRA, ones, first);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("code512_alt%0d", i), int'(pwm), i % 2);
    end

    // Mid-stream asynchronous reset, taken while pwm is high.
    do_reset(10'd300);
    run_count(500, ones, first);
    budget = 0;
    while (pwm !== 1'b1 && budget < 64) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("mid_pwm_high_before_rst", int'(pwm), 1);
    #1 rst = 1'b0;
    #1 check("mid_async_clear", int'(pwm), 0);
    @(negedge clk);
    rst = 1'b1;
    run_count(PERIOD_EDGES + EXTRA, ones, first);
    check("mid_restart_count", ones, 300);

    // Code step 100 -> 700 without reset; residue carries across the step.
    do_reset(10'd100);
    run_count(PERIOD_EDGES, seg1, first);
    check("step_seg1_count", seg1, 100 - EXTRA);
    check("step_seg1_first", first, 11 + EXTRA);
    code = 10'd700;
    run_count(PERIOD_EDGES, ones, first);
    check("step_total_count", seg1 + ones, 800 - EXTRA);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
